// File: rtl/mcrp_control_unit.sv
// rtl/mcrp_control_unit.sv - multi-cycle main control FSM for the MCRP core
// Decodes the IR opcode into per-state datapath strobes; one instruction in flight at a time.
module mcrp_control_unit #(
  parameter int OPC_W      = 6,
  parameter int WAIT_LIMIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero_signal,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic [1:0]       pc_src,
  output logic             ext_op,
  output logic [2:0]       alu_op,
  output logic [1:0]       alu_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             wb_src,
  output logic             stack_write,
  output logic             stack_read,
  output logic             reg_src,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             bus_error
);

  localparam int CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_J    = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_CALL = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_RET  = OPC_W'(10);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ill_q, ill_d;
  logic             bus_q, bus_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      bus_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      bus_q   <= bus_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ill_d       = ill_q;
    bus_d       = bus_q;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    pc_src      = 2'd0;
    ext_op      = 1'b0;
    alu_op      = 3'd0;
    alu_src     = 2'd0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    wb_src      = 1'b0;
    stack_write = 1'b0;
    stack_read  = 1'b0;
    reg_src     = 1'b0;
    instr_done  = 1'b0;

    case (state_q)
      S_IF: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        case (opcode)
          OP_J: begin
            pc_write   = 1'b1;
            pc_src     = 2'd2;
            instr_done = 1'b1;
            state_d    = S_IF;
          end
          // PC was already incremented in IF, so the push saves the return address
          OP_CALL: begin
            stack_write = 1'b1;
            pc_write    = 1'b1;
            pc_src      = 2'd2;
            instr_done  = 1'b1;
            state_d     = S_IF;
          end
          OP_RET: begin
            stack_read = 1'b1;
            pc_write   = 1'b1;
            pc_src     = 2'd3;
            instr_done = 1'b1;
            state_d    = S_IF;
          end
          OP_AND, OP_ADD, OP_SUB, OP_ANDI, OP_ADDI, OP_LW, OP_SW, OP_BEQ: begin
            reg_src = (opcode == OP_SW) || (opcode == OP_BEQ);
            state_d = S_EX;
          end
          default: begin
            ill_d   = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_EX: begin
        if ((opcode == OP_AND) || (opcode == OP_ANDI))      alu_op = 3'd0;
        else if ((opcode == OP_SUB) || (opcode == OP_BEQ))  alu_op = 3'd2;
        else                                                alu_op = 3'd1;
        alu_src = ((opcode == OP_ANDI) || (opcode == OP_ADDI) ||
                   (opcode == OP_LW)   || (opcode == OP_SW)) ? 2'd1 : 2'd0;
        ext_op  = (opcode == OP_ADDI) || (opcode == OP_LW) ||
                  (opcode == OP_SW)   || (opcode == OP_BEQ);
        if (opcode == OP_BEQ) begin
          pc_write   = zero_signal;
          pc_src     = 2'd1;
          instr_done = 1'b1;
          state_d    = S_IF;
        end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
          cnt_d   = '0;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_read  = (opcode == OP_LW);
        mem_write = (opcode == OP_SW);
        if (mem_ready) begin
          cnt_d = '0;
          if (opcode == OP_LW) begin
            state_d = S_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = S_IF;
          end
        end else if (cnt_q == CNT_W'(WAIT_LIMIT)) begin
          // Slave never answered within WAIT_LIMIT+1 cycles of residency
          bus_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        wb_src     = (opcode == OP_LW);
        instr_done = 1'b1;
        state_d    = S_IF;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IF;
      end
    endcase

    if (!reset) begin
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      pc_src      = 2'd0;
      ext_op      = 1'b0;
      alu_op      = 3'd0;
      alu_src     = 2'd0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      wb_src      = 1'b0;
      stack_write = 1'b0;
      stack_read  = 1'b0;
      reg_src     = 1'b0;
      instr_done  = 1'b0;
    end
  end

  assign state      = reset ? state_q : 3'd0;
  assign illegal_op = reset & ill_q;
  assign bus_error  = reset & bus_q;

endmodule

// File: tb/tb_mcrp_control_unit.sv
// tb/tb_mcrp_control_unit.sv - randomized self-checking bench for mcrp_control_unit
// Expected per-cycle strobes come from an instruction-level script built from the ISA rules.
module tb_mcrp_control_unit;

  localparam int WAIT_LIMIT = 15;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic [1:0] pc_src;
    logic       ext_op;
    logic [2:0] alu_op;
    logic [1:0] alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       wb_src;
    logic       stack_write;
    logic       stack_read;
    logic       reg_src;
    logic       instr_done;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero_signal = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, ext_op, mem_read, mem_write, reg_write, wb_src;
  logic       stack_write, stack_read, reg_src, instr_done, illegal_op, bus_error;
  logic [1:0] pc_src, alu_src;
  logic [2:0] alu_op, state;
  ctl_t       act;

  int total = 0;
  int bad   = 0;
  logic exp_ill = 1'b0;
  logic exp_bus = 1'b0;

  mcrp_control_unit #(.OPC_W(6), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero_signal(zero_signal),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .pc_src(pc_src),
    .ext_op(ext_op), .alu_op(alu_op), .alu_src(alu_src), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .wb_src(wb_src),
    .stack_write(stack_write), .stack_read(stack_read), .reg_src(reg_src),
    .state(state), .instr_done(instr_done), .illegal_op(illegal_op), .bus_error(bus_error)
  );

  assign act = '{pc_write, ir_write, pc_src, ext_op, alu_op, alu_src, mem_read, mem_write,
                 reg_write, wb_src, stack_write, stack_read, reg_src, instr_done};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; drives this cycle's inputs, samples mid-cycle, advances one cycle.
  task automatic step(input string tag, input logic [2:0] es, input ctl_t ev,
                      input logic z, input logic rdy);
    zero_signal = z;
    mem_ready   = rdy;
    #3;
    chk({tag, "_state"}, 32'(state), 32'(es));
    chk({tag, "_ctl"}, 32'(act), 32'(ev));
    chk({tag, "_ill"}, 32'(illegal_op), 32'(exp_ill));
    chk({tag, "_bus"}, 32'(bus_error), 32'(exp_bus));
    @(posedge clk);
    #1;
  endtask

  task automatic reset_now(input string tag);
    reset = 1'b0;
    #1;
    chk({tag, "_rst_state"}, 32'(state), 32'd0);
    chk({tag, "_rst_ctl"}, 32'(act), 32'd0);
    chk({tag, "_rst_flags"}, {30'd0, illegal_op, bus_error}, 32'd0);
    exp_ill = 1'b0;
    exp_bus = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic halt_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 3'd7, '0, 1'($urandom), 1'($urandom));
    reset_now(tag);
  endtask

  // waits = MEM cycles with mem_ready low before it rises; > WAIT_LIMIT means never.
  task automatic run_instr(input logic [5:0] op, input logic z, input int waits);
    ctl_t c;
    int   k;
    opcode = op;
    c = '0; c.ir_write = 1'b1; c.pc_write = 1'b1;
    step("IF", 3'd0, c, 1'($urandom), 1'($urandom));

    c = '0;
    if (op == 6'd8 || op == 6'd9 || op == 6'd10) begin
      c.pc_write    = 1'b1;
      c.instr_done  = 1'b1;
      c.pc_src      = (op == 6'd10) ? 2'd3 : 2'd2;
      c.stack_write = (op == 6'd9);
      c.stack_read  = (op == 6'd10);
      step("ID_jmp", 3'd1, c, 1'($urandom), 1'($urandom));
      return;
    end
    if (op > 6'd10) begin
      step("ID_ill", 3'd1, c, 1'($urandom), 1'($urandom));
      exp_ill = 1'b1;
      halt_cycles("HALT_ill", 20);
      return;
    end
    c.reg_src = (op == 6'd6 || op == 6'd7);
    step("ID", 3'd1, c, 1'($urandom), 1'($urandom));

    c = '0;
    case (op)
      6'd0, 6'd3: c.alu_op = 3'd0;
      6'd2, 6'd7: c.alu_op = 3'd2;
      default:    c.alu_op = 3'd1;
    endcase
    c.alu_src = (op >= 6'd3 && op <= 6'd6) ? 2'd1 : 2'd0;
    c.ext_op  = (op >= 6'd4 && op <= 6'd7);
    if (op == 6'd7) begin
      c.pc_write   = z;
      c.pc_src     = 2'd1;
      c.instr_done = 1'b1;
      step("EX_beq", 3'd2, c, z, 1'($urandom));
      return;
    end
    step("EX", 3'd2, c, 1'($urandom), 1'($urandom));

    if (op == 6'd5 || op == 6'd6) begin
      k = 0;
      forever begin
        c = '0;
        c.mem_read   = (op == 6'd5);
        c.mem_write  = (op == 6'd6);
        c.instr_done = (k == waits) && (op == 6'd6);
        step("MEM", 3'd3, c, 1'($urandom), (k == waits));
        if (k == waits) break;
        if (k == WAIT_LIMIT) begin
          exp_bus = 1'b1;
          halt_cycles("HALT_bus", 3);
          return;
        end
        k++;
      end
      if (op == 6'd6) return;
    end

    c = '0;
    c.reg_write  = 1'b1;
    c.wb_src     = (op == 6'd5);
    c.instr_done = 1'b1;
    step("WB", 3'd4, c, 1'($urandom), 1'($urandom));
  endtask

  initial begin
    ctl_t c;
    int   r;
    @(posedge clk);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_ctl", 32'(act), 32'd0);
    chk("reset_flags", {30'd0, illegal_op, bus_error}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr(6'd1, 1'b0, 0);
    run_instr(6'd5, 1'b0, 3);
    run_instr(6'd7, 1'b1, 0);
    run_instr(6'd7, 1'b0, 0);
    run_instr(6'd9, 1'b0, 0);
    run_instr(6'd10, 1'b0, 0);
    run_instr(6'd12, 1'b0, 0);
    run_instr(6'd6, 1'b0, 100);
    run_instr(6'd6, 1'b0, WAIT_LIMIT);

    // Reset pulled low in the middle of EX must return to IF immediately.
    opcode = 6'd6;
    c = '0; c.ir_write = 1'b1; c.pc_write = 1'b1;
    step("IF_mid", 3'd0, c, 1'b0, 1'b0);
    c = '0; c.reg_src = 1'b1;
    step("ID_mid", 3'd1, c, 1'b0, 1'b0);
    #2;
    chk("EX_mid_state", 32'(state), 32'd2);
    reset_now("EX_mid");
    run_instr(6'd4, 1'b0, 0);

    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(99, 0));
      if (r < 4)       run_instr(6'($urandom_range(63, 11)), 1'b0, 0);
      else if (r < 7)  run_instr(6'd5 + 6'($urandom_range(1, 0)), 1'b0, 20);
      else             run_instr(6'($urandom_range(10, 0)), 1'($urandom),
                                 int'($urandom_range(5, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
